// File: rtl/beta_pkg.sv
// Shared Beta definitions: ALU opcodes and the multiply-sequencer state encoding.
package beta_pkg;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_AND   = 5'b01000;
    localparam logic [4:0] ALU_OR    = 5'b01110;
    localparam logic [4:0] ALU_XOR   = 5'b00110;
    localparam logic [4:0] ALU_SHL   = 5'b10000;
    localparam logic [4:0] ALU_SHR   = 5'b10001;
    localparam logic [4:0] ALU_SRA   = 5'b10011;
    localparam logic [4:0] ALU_CMPEQ = 5'b00011;
    localparam logic [4:0] ALU_CMPLT = 5'b00101;
    localparam logic [4:0] ALU_CMPLE = 5'b00111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } mulseq_state_t;

endpackage

// File: rtl/beta_mul_dp.sv
// Shift-and-add datapath for the multiply sequencer: operand registers and ALU operand muxes.
module beta_mul_dp
    import beta_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic             step,
    input  logic             active,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] alu_y,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             last
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mlt;
    logic [5:0]       cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            mcand <= '0;
            mlt   <= '0;
            cnt   <= '0;
        end else if (load) begin
            acc   <= '0;
            mcand <= a;
            mlt   <= b;
            cnt   <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (step) begin
            acc   <= alu_y;
            mcand <= mcand << 1;
            mlt   <= mlt >> 1;
            cnt   <= cnt + 6'd1;
        end
    end

    // Early termination: no set bits remain once this step's shift is applied.
    assign last  = (mlt[WIDTH-1:1] == '0);
    assign alu_a = active ? acc : '0;
    assign alu_b = (active && mlt[0]) ? mcand : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (cnt != 6'd33) else $error("beta_mul_dp: iteration count overflow");
        end
    end

endmodule

// File: rtl/beta_mul_seq.sv
// Iterative multiply sequencer that borrows the shared ALU for one ADD per granted cycle.
module beta_mul_seq
    import beta_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] alu_y
);

    mulseq_state_t state;
    logic          accept;
    logic          b_zero;
    logic          step;
    logic          last;

    assign b_zero  = (b == '0);
    assign accept  = (state == IDLE) && start;
    assign step    = (state == ADD) && alu_gnt;
    assign alu_req = (state == ADD);
    assign alu_op  = ALU_ADD;

    beta_mul_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk   (clk),
        .reset (reset),
        .load  (accept && !b_zero),
        .clear (accept && b_zero),
        .step  (step),
        .active(alu_req),
        .a     (a),
        .b     (b),
        .alu_y (alu_y),
        .alu_a (alu_a),
        .alu_b (alu_b),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (b_zero) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= '0;
                        end else begin
                            state <= ADD;
                        end
                    end
                end
                ADD: begin
                    // The final sum is on alu_y this cycle; capture it as acc updates.
                    if (step && last) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= alu_y;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beta_mul_seq.sv
// Directed-vector bench for beta_mul_seq with a behavioural adder standing in for the ALU.
module tb_beta_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        alu_req;
    logic        alu_gnt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_op;
    logic [31:0] alu_y;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign alu_y = alu_a + alu_b;

    beta_mul_seq #(
        .WIDTH(32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .alu_req(alu_req),
        .alu_gnt(alu_gnt),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_op (alu_op),
        .alu_y  (alu_y)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Starts one multiply and stops in the done cycle (or at the cycle budget).
    task automatic do_mul(input logic [31:0] aa, input logic [31:0] bb,
                          output int cyc, output int reqs);
        a = aa;
        b = bb;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        reqs = 0;
        while (!done && cyc < 100) begin
            reqs += int'(alu_req);
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({busy, done, alu_req} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctrl: busy/done/req=%b required 000", {busy, done, alu_req});
        end
        n_vec++;
        if (result !== 32'd0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 5'd0) begin
            n_err++;
            $display("FAIL reset_data: result=%h alu_a=%h alu_b=%h op=%h required all 0",
                     result, alu_a, alu_b, alu_op);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int cyc, reqs;
        a = 32'd6;
        b = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if (alu_req !== 1'b1 || busy !== 1'b1 || alu_a !== 32'd0 || alu_b !== 32'd6) begin
            n_err++;
            $display("FAIL basic_first_add: req=%b busy=%b alu_a=%h alu_b=%h required 1 1 0 6",
                     alu_req, busy, alu_a, alu_b);
        end
        cyc = 1;
        reqs = 0;
        while (!done && cyc < 100) begin
            reqs += int'(alu_req);
            tick();
            cyc++;
        end
        n_vec++;
        if (cyc !== 4 || reqs !== 3) begin
            n_err++;
            $display("FAIL basic_timing: done_at=%0d add_cycles=%0d required 4 3", cyc, reqs);
        end
        n_vec++;
        if (result !== 32'd42) begin
            n_err++;
            $display("FAIL basic_result: got %0d required 42", result);
        end
        tick();
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_idle: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_zero();
        a = 32'h12345678;
        b = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if (done !== 1'b1 || alu_req !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL zero_timing: done=%b req=%b busy=%b required 1 0 1",
                     done, alu_req, busy);
        end
        n_vec++;
        if (result !== 32'd0) begin
            n_err++;
            $display("FAIL zero_result: got %h required 00000000", result);
        end
        tick();
    endtask

    task automatic test_wrap();
        int cyc, reqs;
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, cyc, reqs);
        n_vec++;
        if (cyc !== 33 || reqs !== 32) begin
            n_err++;
            $display("FAIL max_timing: done_at=%0d add_cycles=%0d required 33 32", cyc, reqs);
        end
        n_vec++;
        if (result !== 32'h00000001) begin
            n_err++;
            $display("FAIL max_result: got %h required 00000001", result);
        end
        tick();
        do_mul(32'hFFFFFFFF, 32'd5, cyc, reqs);
        n_vec++;
        if (cyc !== 4 || result !== 32'hFFFFFFFB) begin
            n_err++;
            $display("FAIL neg_result: done_at=%0d result=%h required 4 FFFFFFFB", cyc, result);
        end
        tick();
    endtask

    task automatic test_stall();
        int cyc;
        a = 32'd3;
        b = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        alu_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (alu_a !== 32'd3 || alu_req !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: alu_a=%0d req=%b done=%b required 3 1 0",
                         i, alu_a, alu_req, done);
            end
        end
        alu_gnt = 1'b1;
        cyc = 6;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        n_vec++;
        if (cyc !== 8 || result !== 32'd15) begin
            n_err++;
            $display("FAIL stall_result: done_at=%0d result=%0d required 8 15", cyc, result);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int cyc;
        a = 32'd6;
        b = 32'd7;
        start = 1'b1;
        tick();
        a = 32'd100;
        b = 32'd100;
        cyc = 1;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        start = 1'b0;
        n_vec++;
        if (cyc !== 4 || result !== 32'd42) begin
            n_err++;
            $display("FAIL ignore_start: done_at=%0d result=%0d required 4 42", cyc, result);
        end
        for (int i = 0; i < 3; i++) tick();
        n_vec++;
        if (result !== 32'd42 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_hold: result=%0d busy=%b required 42 0", result, busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, reqs;
        do_mul(32'd9, 32'd11, cyc, reqs);
        tick();
        do_mul(32'd13, 32'd2, cyc, reqs);
        n_vec++;
        if (cyc !== 3 || result !== 32'd26) begin
            n_err++;
            $display("FAIL back_to_back: done_at=%0d result=%0d required 3 26", cyc, result);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        int cyc, reqs;
        a = 32'd100;
        b = 32'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if ({busy, done, alu_req} !== 3'b000 || result !== 32'd0 || alu_a !== 32'd0) begin
            n_err++;
            $display("FAIL mid_reset: busy/done/req=%b result=%h alu_a=%h required 000 0 0",
                     {busy, done, alu_req}, result, alu_a);
        end
        tick();
        do_mul(32'd100, 32'd200, cyc, reqs);
        n_vec++;
        if (cyc !== 9 || result !== 32'd20000) begin
            n_err++;
            $display("FAIL after_reset: done_at=%0d result=%0d required 9 20000", cyc, result);
        end
        tick();
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        alu_gnt = 1'b1;
        test_reset();
        test_basic();
        test_zero();
        test_wrap();
        test_stall();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/beta_mul_seq.md
# beta_mul_seq

Iterative 32×32→32 multiply sequencer that borrows the shared Beta ALU to execute MUL/MULC without a dedicated multiplier array. It sits beside the execute stage: it accepts an operand pair, requests the ALU through a request/grant handshake, and issues one ALU ADD per granted cycle. It returns the low 32 bits of the product, which are identical for signed and unsigned operands.

## Interface
- `WIDTH`, 32, operand/result width; the ALU datapath is fixed at 32.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: accept request; honoured only in IDLE.
- `a` in 32: multiplicand, sampled on accepted start.
- `b` in 32: multiplier, sampled on accepted start.
- `busy` out 1: high in ADD and DONE.
- `done` out 1: one-cycle pulse in DONE.
- `result` out 32: product low word; holds its value until the next accepted start.
- `alu_req` out 1: requests the shared ALU; high exactly in ADD.
- `alu_gnt` in 1: ALU granted this cycle; may drop at any time.
- `alu_a` out 32: ALU operand A.
- `alu_b` out 32: ALU operand B.
- `alu_op` out 5: ALU opcode; constant ADD (5'b00000).
- `alu_y` in 32: ALU result, combinational within the same cycle.

## Operation
- Internal registers:
  - `acc` (32): running sum.
  - `mcand` (32): shifted multiplicand.
  - `mlt` (32): shifted multiplier.
  - `cnt` (6): granted-iteration counter.
- States are IDLE, ADD and DONE.
- IDLE:
  - If `start` is high and `b` ≠ 0: `acc`←0, `mcand`←`a`, `mlt`←`b`, `cnt`←0, go to ADD.
  - If `start` is high and `b` = 0: `acc`←0, go to DONE.
- ADD:
  - `alu_a`=`acc`.
  - `alu_b`=`mlt[0]` ? `mcand` : 0.
  - `alu_op`=ADD.
- ADD with `alu_gnt`=1:
  - `acc`←`alu_y`, `mcand`←`mcand`<<1, `mlt`←`mlt`>>1, `cnt`←`cnt`+1.
  - If the shifted `mlt` is 0, go to DONE. This is early termination.
- ADD with `alu_gnt`=0: all registers hold and the state stays ADD.
- DONE:
  - `done`=1 and `result`←`acc` (registered on entry).
  - Return to IDLE next cycle.
  - `start` in DONE is ignored.
- `start` during ADD/DONE is ignored; the operands are not re-sampled.
- ALU carry out of bit 31 is discarded (mod 2^32). The `z`/`v`/`n` flags are ignored.
- Outside ADD: `alu_a`=`alu_b`=0 and `alu_op`=ADD.
- `cnt` never exceeds 32; `mlt`=0 always terminates by then. An assertion flags `cnt`=33.

## Timing
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `result`=0, `alu_req`=0, `alu_a`=0, `alu_b`=0, `alu_op`=5'b00000.
  - `acc`/`mcand`/`mlt`/`cnt`=0.
- Start is sampled at edge t.
- With `b`≠0 and N = index of highest set bit of `b` + 1, plus G stall cycles:
  - ADD occupies cycles t+1 … t+N+G.
  - `done` is high in cycle t+N+G+1, and `result` is valid from that cycle.
- With `b`=0: `done` is high in cycle t+1, with `result`=0.
- Back-to-back: the next start is accepted earliest in the cycle after `done`.
- `alu_req` is combinational from state. `alu_a`/`alu_b` are combinational from registers.
- `alu_gnt` is sampled only in ADD.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. No `done` is emitted, and the previous `result` is cleared to 0.

## Structure
- Shared package `beta_pkg`:
  - ALU opcode constants (`ALU_ADD`=5'b00000, `ALU_SUB`=5'b00001, plus the shift/compare/boolean codes).
  - The `mulseq_state_t` enum {IDLE, ADD, DONE}.
- One sub-module, `beta_mul_dp`: registers `acc`/`mcand`/`mlt`/`cnt` and the `alu_b` mux.
- The FSM and handshake stay in `beta_mul_seq`.
- The ALU is not instantiated here. The top-level ALU-sharing mux selects between pipeline operands and `alu_a`/`alu_b`/`alu_op` on `alu_gnt`.

## Test plan
- `a`=6, `b`=7, `alu_gnt`=1 → 3 ADD cycles, `done` at t+4, `result`=42.
- `a`=0x12345678, `b`=0 → no `alu_req`, `done` at t+1, `result`=0.
- `a`=`b`=0xFFFFFFFF, `alu_gnt`=1 → 32 ADD cycles, `done` at t+33, `result`=0x00000001; also `a`=0xFFFFFFFF (−1), `b`=5 → `result`=0xFFFFFFFB.
- `a`=3, `b`=5, `alu_gnt` low for 4 cycles mid-ADD → registers frozen during stall, `done` at t+3+4+1=t+8, `result`=15.
- `start` pulsed in ADD and DONE with different operands → ignored, `result` from the first pair; result held stable in IDLE until the next start.
- `reset` asserted in the second ADD cycle of 100×200 → IDLE, `busy`/`done`/`alu_req`/`result` all 0 next cycle; a subsequent 100×200 gives 20000.
